// File: rtl/fram_axis_bridge.sv
// rtl/fram_axis_bridge.sv - frame word stream to AXI-Stream bridge with alignment FSM and drop status
// Optional DropCount/FrameCount statistics are built only when FRAM_BRIDGE_STATS_EN is defined.
module fram_axis_bridge #(
  parameter int DATA_SIZE   = 12,
  parameter int LENGTH      = 32768,
  parameter int LENGTH_SIZE = 15,
  parameter int FIFO_AW     = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_SIZE-1:0]   FramData,
  input  logic [LENGTH_SIZE-1:0] FramAdd,
  input  logic                   FramEn,
  input  logic                   Clear,
  output logic [31:0]            M_tdata,
  output logic [3:0]             M_tkeep,
  output logic                   M_tlast,
  output logic                   M_tvalid,
  input  logic                   M_tready,
  output logic                   Overflow,
  output logic [15:0]            DropCount,
  output logic [15:0]            FrameCount
);
  localparam logic [FIFO_AW:0]       DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [LENGTH_SIZE-1:0] LAST_ADD = LENGTH_SIZE'(LENGTH - 1);

  typedef enum logic [1:0] {SYNC, PASS, DISCARD} state_t;
  state_t state, state_nxt;

  logic [DATA_SIZE:0]   mem [2**FIFO_AW];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic                 pop, accept, push, drop, frame_start;

  assign pop         = (count != '0) && M_tready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign accept      = (count != DEPTH) || pop;
  assign frame_start = FramEn && (FramAdd == '0);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    case (state)
      SYNC, DISCARD: begin
        if (frame_start && accept) begin
          push      = 1'b1;
          state_nxt = PASS;
        end
      end
      PASS: begin
        if (FramEn) begin
          if (accept) begin
            push = 1'b1;
          end else begin
            drop      = 1'b1;
            state_nxt = DISCARD;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= SYNC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop)       Overflow <= 1'b1;
      else if (Clear) Overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {FramAdd == LAST_ADD, FramData};
  end

  assign M_tvalid = (count != '0);
  assign M_tdata  = 32'(mem[rd_ptr][DATA_SIZE-1:0]);
  // Gated so an empty FIFO never presents stale tlast.
  assign M_tlast  = M_tvalid && mem[rd_ptr][DATA_SIZE];
  assign M_tkeep  = 4'hF;

`ifdef FRAM_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      DropCount  <= '0;
      FrameCount <= '0;
    end else begin
      if (drop)
        DropCount <= Clear ? 16'd1 : ((DropCount == 16'hFFFF) ? DropCount : DropCount + 1'b1);
      else if (Clear)
        DropCount <= '0;
      if (pop && M_tlast) FrameCount <= FrameCount + 1'b1;
    end
  end
`else
  assign DropCount  = '0;
  assign FrameCount = '0;
`endif
endmodule

// File: doc/fram_axis_bridge.md
FRAM_AXIS_BRIDGE -- requirements
Module: fram_axis_bridge

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, both as ports: clk and rstn.
REQ-002 Parameter DATA_SIZE, default 12: width of a frame data word.
REQ-003 Parameter LENGTH, default 32768: number of words in one frame.
REQ-004 Parameter LENGTH_SIZE, default 15: width of the frame address.
REQ-005 Parameter FIFO_AW, default 4: FIFO address width, giving depth 2^FIFO_AW.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rstn, in, 1: async active-low reset.
- FramData, in, DATA_SIZE: frame word.
- FramAdd, in, LENGTH_SIZE: word index within the frame.
- FramEn, in, 1: word valid. There is no backpressure on this input.
- Clear, in, 1: clears the sticky status.
- M_tdata, out, 32: AXI-Stream data.
- M_tkeep, out, 4: AXI-Stream byte enables.
- M_tlast, out, 1: last word of a frame.
- M_tvalid, out, 1: AXI-Stream valid.
- M_tready, in, 1: AXI-Stream ready.
- Overflow, out, 1: sticky flag, set when a word is dropped.
- DropCount, out, 16: number of dropped words.
- FrameCount, out, 16: number of frames emitted.

Function
REQ-007 The FIFO SHALL be synchronous, 2^FIFO_AW entries deep, with each entry holding {last, data}; last is set when FramAdd == LENGTH-1.
REQ-008 The alignment FSM SHALL have three states: SYNC, PASS and DISCARD.
REQ-009 SYNC: words are not written; on FramEn with FramAdd == 0 the FSM SHALL go to PASS and write that same word.
REQ-010 PASS: each FramEn word SHALL be written if it is accepted; a refused word SHALL cause a drop and a move to DISCARD.
REQ-011 DISCARD: all words SHALL be dropped silently, without incrementing DropCount, until FramEn with FramAdd == 0; that word SHALL be written if accepted and the FSM SHALL return to PASS.
REQ-012 A write SHALL be accepted when occupancy < depth, or when occupancy == depth and a pop occurs in the same cycle.
REQ-013 A pop SHALL occur when M_tvalid && M_tready.
REQ-014 M_tvalid SHALL equal (occupancy != 0).
REQ-015 M_tdata SHALL be the head data zero-extended to 32 bits; M_tlast SHALL be the head last bit; M_tkeep SHALL be constant 4'hF.
REQ-016 Latency: a word written in cycle N SHALL be visible at the FIFO head no earlier than cycle N+1; there SHALL be no combinational path from FramEn to M_tvalid.
REQ-017 M_tdata and M_tlast SHALL remain stable while M_tvalid && !M_tready.
REQ-018 Occupancy SHALL be unchanged on a simultaneous push and pop; pointers SHALL wrap modulo the depth.
REQ-019 A drop SHALL set Overflow and increment DropCount, saturating at 16'hFFFF.
REQ-020 Clear SHALL zero Overflow and DropCount next cycle; a drop in the same cycle as Clear SHALL win, leaving Overflow=1 and DropCount=1.
REQ-021 A frame truncated by overflow carries no tlast; on Overflow, software re-arms the DMA.
REQ-022 FrameCount SHALL increment on each pop with M_tlast=1, wrapping modulo 2^16, and SHALL NOT be affected by Clear.

Reset
REQ-023 Assertion of rstn low SHALL immediately set the FSM to SYNC, clear occupancy and pointers, and force Overflow=0, DropCount=0, FrameCount=0, M_tvalid=0 and M_tlast=0.
REQ-024 Reset mid-frame SHALL discard FIFO contents; after release, output SHALL resume at the next FramAdd == 0.

Configuration
REQ-025 Macro FRAM_BRIDGE_STATS_EN: when defined, DropCount and FrameCount SHALL be implemented as specified above.
REQ-026 When FRAM_BRIDGE_STATS_EN is undefined, DropCount and FrameCount SHALL be tied to 0, no counter logic SHALL be present, and Overflow behaviour SHALL be unchanged.

Verification
REQ-027 The bench SHALL cover, with LENGTH=256, LENGTH_SIZE=8, FIFO_AW=4:
- Reset release, then FramEn stream starting at FramAdd=5 -> no M_tvalid until FramAdd wraps to 0; the first output word is the one with FramAdd 0.
- Full frame at 1 word/cycle with M_tready=1 -> 256 words out, M_tlast only on word 255, FrameCount=1, Overflow=0.
- M_tready=0 for 20 cycles mid-frame -> the 17th pending word is dropped, Overflow=1, DropCount=1, FSM in DISCARD, no more writes until FramAdd=0.
- FIFO full with M_tready=1 and FramEn both asserted in the same cycle -> write accepted, occupancy stays 16, no drop.
- Clear and a drop in the same cycle -> Overflow=1, DropCount=1; Clear alone in the next cycle -> Overflow=0, DropCount=0.
- rstn pulsed low with 8 words buffered -> M_tvalid=0 immediately; realignment at the next FramAdd=0; FrameCount=0.
